// File: rtl/seq_bin_multiplier_if.sv
// Operand/result bundle for seq_bin_multiplier: the requester drives the
// operands and start, the multiplier returns busy/done and the product.
interface seq_bin_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output is_signed,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  is_signed,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_bin_multiplier.sv
// Sequential shift-and-add multiplier: one partial product per clock, signed
// operands handled as magnitudes with the sign reapplied on the final sum.
module seq_bin_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_bin_multiplier_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_P     = PW'(1);
    localparam logic [CW-1:0]    ONE_C     = CW'(1);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]       state_r;
    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic             neg_r;
    logic [PW-1:0]    acc_r;
    logic [CW-1:0]    count_r;
    logic [PW-1:0]    product_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic             neg_s;
    logic [PW-1:0]    sum_s;
    logic [PW-1:0]    final_s;

    // The magnitude of the most negative value still fits WIDTH bits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
        if (s && v[WIDTH-1]) begin
            return ~v + ONE_W;
        end else begin
            return v;
        end
    endfunction

    // Operand conditioning and one accumulation step.
    always_comb begin
        a_mag_s = magnitude(bus.a, bus.is_signed);
        b_mag_s = magnitude(bus.b, bus.is_signed);
        neg_s   = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        sum_s   = acc_r;
        final_s = acc_r;
        if (mplier_r[0]) begin
            sum_s = acc_r + mcand_r;
        end else begin
            sum_s = acc_r;
        end
        if (neg_r) begin
            final_s = ~sum_s + ONE_P;
        end else begin
            final_s = sum_s;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            mcand_r   <= {PW{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            neg_r     <= 1'b0;
            acc_r     <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            product_r <= {PW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        mcand_r  <= {{WIDTH{1'b0}}, a_mag_s};
                        mplier_r <= b_mag_s;
                        neg_r    <= neg_s;
                        acc_r    <= {PW{1'b0}};
                        count_r  <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r    <= sum_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r + ONE_C;
                    // The sign is applied only on the way out, so product never sees a partial sum.
                    if (count_r == LAST_STEP) begin
                        product_r <= final_s;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                        state_r   <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule
